// File: rtl/ddr_defs_pkg.sv
// Shared command/state encodings and default timing for the DDR command executor.
package ddr_defs;

   localparam int unsigned TIMER_W = 4;

   // DDR command bus encodings, {ras_n, cas_n, we_n}
   localparam logic [2:0] CMD_NOP   = 3'b111;
   localparam logic [2:0] CMD_ACT   = 3'b011;
   localparam logic [2:0] CMD_READ  = 3'b101;
   localparam logic [2:0] CMD_WRITE = 3'b100;
   localparam logic [2:0] CMD_PRE   = 3'b010;
   localparam logic [2:0] CMD_REF   = 3'b001;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_REFRESH  = 3'd1;
   localparam logic [2:0] ST_ACT_WAIT = 3'd2;
   localparam logic [2:0] ST_COL      = 3'd3;
   localparam logic [2:0] ST_GAP      = 3'd4;
   localparam logic [2:0] ST_PRE      = 3'd5;
   localparam logic [2:0] ST_RECOVER  = 3'd6;

   localparam int unsigned DEF_TRCD  = 2;
   localparam int unsigned DEF_TRP   = 2;
   localparam int unsigned DEF_TWR   = 2;
   localparam int unsigned DEF_TRFC  = 8;
   localparam int unsigned DEF_BURST = 2;

   // Clamp a wait length to the timer range so large parameter sums cannot wrap.
   function automatic logic [TIMER_W-1:0] timer_load(input int unsigned cycles);
      if (cycles > 15) return '1;
      return cycles[TIMER_W-1:0];
   endfunction

endpackage

// File: rtl/ddr_delay_timer.sv
// Loadable 4-bit down-counter shared by every wait state; last flags the final wait cycle.
module ddr_delay_timer
   import ddr_defs::*;
(
   input  logic               clock_i,
   input  logic               reset_i,
   input  logic               load,
   input  logic [TIMER_W-1:0] value,
   output logic               last
);

   logic [TIMER_W-1:0] count;

   always_ff @(posedge clock_i) begin
      if (reset_i)
         count <= '0;
      else if (load)
         count <= value;
      else if (count != '0)
         count <= count - 1'b1;
   end

   // The state leaves on the edge where the count drops to zero, keeping spacing exact.
   assign last = (count <= TIMER_W'(1));

endmodule

// File: rtl/ddr_cmd_executor.sv
// Turns sequencer start/column requests into timed DDR ACTIVE/READ/WRITE/PRECHARGE/REFRESH commands.
module ddr_cmd_executor
   import ddr_defs::*;
#(
   parameter int unsigned TRCD         = DEF_TRCD,
   parameter int unsigned TRP          = DEF_TRP,
   parameter int unsigned TWR          = DEF_TWR,
   parameter int unsigned TRFC         = DEF_TRFC,
   parameter int unsigned BURST_CYCLES = DEF_BURST
) (
   input  logic        clock_i,
   input  logic        reset_i,
   input  logic        enable_i,
   input  logic        refresh_req_i,
   output logic        refresh_ack_o,
   input  logic        cmd_start_i,
   input  logic        cmd_read_i,
   input  logic        cmd_last_i,
   input  logic [1:0]  cmd_bank_i,
   input  logic [12:0] cmd_row_i,
   input  logic [8:0]  cmd_col_i,
   output logic        cmd_exec_o,
   output logic        ddr_idle_o,
   output logic [2:0]  ddr_cmd_o,
   output logic [1:0]  ddr_ba_o,
   output logic [12:0] ddr_a_o,
   output logic        rd_start_o,
   output logic        wr_start_o
);

   localparam logic [TIMER_W-1:0] LD_TRCD  = timer_load(TRCD - 1);
   localparam logic [TIMER_W-1:0] LD_TRP   = timer_load(TRP - 1);
   localparam logic [TIMER_W-1:0] LD_TRFC  = timer_load(TRFC - 1);
   localparam logic [TIMER_W-1:0] LD_BURST = timer_load(BURST_CYCLES - 1);
   localparam logic [TIMER_W-1:0] LD_RREC  = timer_load(BURST_CYCLES + TRP - 1);
   localparam logic [TIMER_W-1:0] LD_WREC  = timer_load(BURST_CYCLES + TWR + TRP - 1);

   logic [2:0]         state, state_nxt;
   logic [2:0]         cmd_nxt;
   logic [1:0]         ba_nxt, bank_q;
   logic [12:0]        a_nxt;
   logic               exec_nxt, rd_nxt, wr_nxt, ack_nxt, latch, rd_q;
   logic               tmr_load, tmr_last;
   logic [TIMER_W-1:0] tmr_val;

   ddr_delay_timer u_timer (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .load    (tmr_load),
      .value   (tmr_val),
      .last    (tmr_last)
   );

   always_comb begin
      state_nxt = state;
      cmd_nxt   = CMD_NOP;
      ba_nxt    = '0;
      a_nxt     = '0;
      exec_nxt  = 1'b0;
      rd_nxt    = 1'b0;
      wr_nxt    = 1'b0;
      ack_nxt   = 1'b0;
      latch     = 1'b0;
      tmr_load  = 1'b0;
      tmr_val   = '0;
      case (state)
         ST_IDLE: begin
            // Banks are all closed here, so refresh can go out without a precharge.
            if (refresh_req_i) begin
               cmd_nxt   = CMD_REF;
               ack_nxt   = 1'b1;
               tmr_load  = 1'b1;
               tmr_val   = LD_TRFC;
               state_nxt = (LD_TRFC == '0) ? ST_IDLE : ST_REFRESH;
            end else if (cmd_start_i && enable_i) begin
               cmd_nxt   = CMD_ACT;
               ba_nxt    = cmd_bank_i;
               a_nxt     = cmd_row_i;
               latch     = 1'b1;
               tmr_load  = 1'b1;
               tmr_val   = LD_TRCD;
               state_nxt = (LD_TRCD == '0) ? ST_COL : ST_ACT_WAIT;
            end
         end
         ST_ACT_WAIT, ST_GAP: begin
            if (tmr_last) state_nxt = ST_COL;
         end
         ST_COL: begin
            ba_nxt   = bank_q;
            tmr_load = 1'b1;
            if (!cmd_start_i) begin
               cmd_nxt   = CMD_PRE;
               tmr_val   = LD_TRP;
               state_nxt = (LD_TRP == '0) ? ST_IDLE : ST_PRE;
            end else begin
               cmd_nxt  = rd_q ? CMD_READ : CMD_WRITE;
               a_nxt    = {2'b00, cmd_last_i, 1'b0, cmd_col_i};
               exec_nxt = 1'b1;
               rd_nxt   = rd_q;
               wr_nxt   = ~rd_q;
               if (cmd_last_i) begin
                  tmr_val   = rd_q ? LD_RREC : LD_WREC;
                  state_nxt = ST_RECOVER;
               end else begin
                  tmr_val   = LD_BURST;
                  state_nxt = (LD_BURST == '0) ? ST_COL : ST_GAP;
               end
            end
         end
         ST_REFRESH, ST_PRE, ST_RECOVER: begin
            if (tmr_last) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state         <= ST_IDLE;
         ddr_cmd_o     <= CMD_NOP;
         ddr_ba_o      <= '0;
         ddr_a_o       <= '0;
         cmd_exec_o    <= 1'b0;
         rd_start_o    <= 1'b0;
         wr_start_o    <= 1'b0;
         refresh_ack_o <= 1'b0;
         ddr_idle_o    <= 1'b1;
      end else begin
         state         <= state_nxt;
         ddr_cmd_o     <= cmd_nxt;
         ddr_ba_o      <= ba_nxt;
         ddr_a_o       <= a_nxt;
         cmd_exec_o    <= exec_nxt;
         rd_start_o    <= rd_nxt;
         wr_start_o    <= wr_nxt;
         refresh_ack_o <= ack_nxt;
         ddr_idle_o    <= (state == ST_IDLE) & ~cmd_start_i & ~refresh_req_i;
      end
   end

   always_ff @(posedge clock_i) begin
      if (latch) begin
         rd_q   <= cmd_read_i;
         bank_q <= cmd_bank_i;
      end
   end

endmodule

// File: tb/tb_ddr_cmd_executor.sv
// Randomized transaction-level bench for ddr_cmd_executor with a timeline reference model.
module tb_ddr_cmd_executor;

   localparam int TRCD  = 2;
   localparam int TRP   = 2;
   localparam int TWR   = 2;
   localparam int TRFC  = 8;
   localparam int BURST = 2;

   localparam logic [2:0] C_NOP = 3'b111;
   localparam logic [2:0] C_ACT = 3'b011;
   localparam logic [2:0] C_RD  = 3'b101;
   localparam logic [2:0] C_WR  = 3'b100;
   localparam logic [2:0] C_PRE = 3'b010;
   localparam logic [2:0] C_REF = 3'b001;

   logic        clock_i = 1'b0;
   logic        reset_i = 1'b1;
   logic        enable_i = 1'b0;
   logic        refresh_req_i = 1'b0;
   logic        cmd_start_i = 1'b0;
   logic        cmd_read_i = 1'b0;
   logic        cmd_last_i = 1'b0;
   logic [1:0]  cmd_bank_i = '0;
   logic [12:0] cmd_row_i = '0;
   logic [8:0]  cmd_col_i = '0;
   logic        refresh_ack_o, cmd_exec_o, ddr_idle_o, rd_start_o, wr_start_o;
   logic [2:0]  ddr_cmd_o;
   logic [1:0]  ddr_ba_o;
   logic [12:0] ddr_a_o;

   int cyc = 0;
   int ready_cyc = 0;
   int checks = 0;
   int failures = 0;

   ddr_cmd_executor #(
      .TRCD(TRCD), .TRP(TRP), .TWR(TWR), .TRFC(TRFC), .BURST_CYCLES(BURST)
   ) dut (
      .clock_i       (clock_i),
      .reset_i       (reset_i),
      .enable_i      (enable_i),
      .refresh_req_i (refresh_req_i),
      .refresh_ack_o (refresh_ack_o),
      .cmd_start_i   (cmd_start_i),
      .cmd_read_i    (cmd_read_i),
      .cmd_last_i    (cmd_last_i),
      .cmd_bank_i    (cmd_bank_i),
      .cmd_row_i     (cmd_row_i),
      .cmd_col_i     (cmd_col_i),
      .cmd_exec_o    (cmd_exec_o),
      .ddr_idle_o    (ddr_idle_o),
      .ddr_cmd_o     (ddr_cmd_o),
      .ddr_ba_o      (ddr_ba_o),
      .ddr_a_o       (ddr_a_o),
      .rd_start_o    (rd_start_o),
      .wr_start_o    (wr_start_o)
   );

   always #5 clock_i = ~clock_i;
   always @(posedge clock_i) cyc <= cyc + 1;

   function automatic logic [21:0] out_vec();
      return {ddr_cmd_o, ddr_ba_o, ddr_a_o, cmd_exec_o, rd_start_o, wr_start_o, refresh_ack_o};
   endfunction

   // Plays the sequencer for one transfer and checks every output cycle against a timeline:
   // ACTIVE at a0, column i at a0+TRCD+i*BURST, then precharge or recovery until ready.
   task automatic run_xfer(input bit rd, input logic [1:0] bank, input logic [12:0] row,
                           input int n, input int abort_k, input logic [8:0] base,
                           input int stride, input bit rnd, input bit en_drop);
      logic [8:0]  cols [8];
      logic [21:0] exp_v [64];
      logic [21:0] exp_m [64];
      logic [21:0] got;
      int a0, ncol, ci, span, o;
      bit lst;
      for (int i = 0; i < 8; i++) cols[i] = rnd ? 9'($urandom) : 9'(int'(base) + i * stride);
      for (int i = 0; i < 64; i++) begin
         exp_v[i] = {C_NOP, 19'h0};
         exp_m[i] = {3'b111, 15'h0, 4'hF};
      end
      exp_v[0] = {C_ACT, bank, row, 4'b0000};
      exp_m[0] = '1;
      ncol = (abort_k != 0) ? abort_k : n;
      for (int i = 0; i < ncol; i++) begin
         o = TRCD + i * BURST;
         lst = (abort_k == 0) && (i == n - 1);
         exp_v[o] = {rd ? C_RD : C_WR, bank, 2'b00, lst, 1'b0, cols[i], 1'b1, rd, !rd, 1'b0};
         exp_m[o] = '1;
      end
      if (abort_k != 0) begin
         o = TRCD + abort_k * BURST;
         exp_v[o] = {C_PRE, bank, 13'h0, 4'b0000};
         exp_m[o] = {3'b111, 2'b11, 13'h0400, 4'hF};
         span = o + TRP;
      end else begin
         span = TRCD + n * BURST + TRP + (rd ? 0 : TWR);
      end
      enable_i    = 1'b1;
      cmd_start_i = 1'b1;
      cmd_read_i  = rd;
      cmd_bank_i  = bank;
      cmd_row_i   = row;
      ci          = 0;
      cmd_col_i   = cols[0];
      cmd_last_i  = (abort_k == 0) && (n == 1);
      a0 = (cyc + 1 > ready_cyc) ? cyc + 1 : ready_cyc;
      ready_cyc = a0 + span;
      while (cyc < ready_cyc - 1) begin
         @(negedge clock_i);
         if (cyc >= a0) begin
            o = cyc - a0;
            got = out_vec();
            checks++;
            if ((got & exp_m[o]) !== (exp_v[o] & exp_m[o])) begin
               failures++;
               $display("FAIL xfer cyc=%0d off=%0d got=%h expected=%h", cyc, o,
                        got & exp_m[o], exp_v[o] & exp_m[o]);
            end
         end
         if (en_drop && cyc == a0) enable_i = 1'b0;
         if (cmd_exec_o === 1'b1 && cmd_start_i) begin
            ci++;
            if (ci == ncol) cmd_start_i = 1'b0;
            else if (ci < 8) begin
               cmd_col_i  = cols[ci];
               cmd_last_i = (abort_k == 0) && (ci == n - 1);
            end
         end
      end
      enable_i = 1'b1;
   endtask

   task automatic do_refresh(input bit en_low);
      int r;
      enable_i      = !en_low;
      refresh_req_i = 1'b1;
      r = (cyc + 1 > ready_cyc) ? cyc + 1 : ready_cyc;
      while (cyc < r) begin
         @(negedge clock_i);
         if (cyc < r) begin
            checks++;
            if (ddr_cmd_o !== C_NOP) begin
               failures++;
               $display("FAIL refresh_early cyc=%0d got=%b expected=%b", cyc, ddr_cmd_o, C_NOP);
            end
         end
      end
      checks++;
      if ({ddr_cmd_o, refresh_ack_o, cmd_exec_o} !== {C_REF, 2'b10}) begin
         failures++;
         $display("FAIL refresh_issue cyc=%0d got=%b expected=%b", cyc,
                  {ddr_cmd_o, refresh_ack_o, cmd_exec_o}, {C_REF, 2'b10});
      end
      refresh_req_i = 1'b0;
      @(negedge clock_i);
      checks++;
      if ({ddr_cmd_o, refresh_ack_o} !== {C_NOP, 1'b0}) begin
         failures++;
         $display("FAIL refresh_ack_pulse got=%b expected=%b", {ddr_cmd_o, refresh_ack_o}, {C_NOP, 1'b0});
      end
      ready_cyc = r + TRFC;
      enable_i = 1'b1;
   endtask

   task automatic test_reset();
      reset_i = 1'b1;
      repeat (3) @(negedge clock_i);
      checks++;
      if ({out_vec(), ddr_idle_o} !== {C_NOP, 19'h0, 1'b1}) begin
         failures++;
         $display("FAIL reset_values got=%h expected=%h", {out_vec(), ddr_idle_o}, {C_NOP, 19'h0, 1'b1});
      end
      reset_i = 1'b0;
      ready_cyc = cyc + 1;
      @(negedge clock_i);
      checks++;
      if ({ddr_cmd_o, ddr_idle_o} !== {C_NOP, 1'b1}) begin
         failures++;
         $display("FAIL idle_after_reset got=%b expected=%b", {ddr_cmd_o, ddr_idle_o}, {C_NOP, 1'b1});
      end
   endtask

   task automatic test_single_read();
      run_xfer(1'b1, 2'd2, 13'h0123, 1, 0, 9'h010, 0, 1'b0, 1'b0);
      @(negedge clock_i);
      checks++;
      if ({ddr_cmd_o, ddr_idle_o} !== {C_NOP, 1'b1}) begin
         failures++;
         $display("FAIL read_idle got=%b expected=%b", {ddr_cmd_o, ddr_idle_o}, {C_NOP, 1'b1});
      end
   endtask

   task automatic test_block_write();
      run_xfer(1'b0, 2'($urandom), 13'($urandom), 3, 0, 9'h000, 4, 1'b0, 1'b0);
      @(negedge clock_i);
      checks++;
      if (ddr_idle_o !== 1'b1) begin
         failures++;
         $display("FAIL write_idle got=%b expected=1", ddr_idle_o);
      end
   endtask

   task automatic test_refresh_vs_start();
      cmd_start_i = 1'b1;
      cmd_read_i  = 1'b1;
      cmd_bank_i  = 2'd3;
      cmd_row_i   = 13'h1FFF;
      cmd_last_i  = 1'b1;
      do_refresh(1'b0);
      run_xfer(1'b1, 2'd3, 13'h1FFF, 2, 0, 9'h1F0, 8, 1'b0, 1'b0);
   endtask

   task automatic test_abort();
      run_xfer(1'($urandom), 2'd1, 13'($urandom), 3, 1, 9'h020, 1, 1'b0, 1'b0);
      @(negedge clock_i);
      checks++;
      if (ddr_idle_o !== 1'b1) begin
         failures++;
         $display("FAIL abort_idle got=%b expected=1", ddr_idle_o);
      end
   endtask

   task automatic test_enable();
      enable_i    = 1'b0;
      cmd_start_i = 1'b1;
      cmd_read_i  = 1'b0;
      cmd_last_i  = 1'b0;
      if (cyc + 1 < ready_cyc) repeat (ready_cyc - cyc - 1) @(negedge clock_i);
      repeat (3) begin
         @(negedge clock_i);
         checks++;
         if ({ddr_cmd_o, ddr_idle_o} !== {C_NOP, 1'b0}) begin
            failures++;
            $display("FAIL enable_hold got=%b expected=%b", {ddr_cmd_o, ddr_idle_o}, {C_NOP, 1'b0});
         end
      end
      run_xfer(1'b0, 2'($urandom), 13'($urandom), 2, 0, 9'h0, 0, 1'b1, 1'b1);
      do_refresh(1'b1);
   endtask

   task automatic test_reset_in_gap();
      bit seen;
      seen = 1'b0;
      enable_i    = 1'b1;
      cmd_start_i = 1'b1;
      cmd_read_i  = 1'b1;
      cmd_bank_i  = 2'd1;
      cmd_row_i   = 13'h0ABC;
      cmd_col_i   = 9'h005;
      cmd_last_i  = 1'b0;
      for (int i = 0; i < 24 && !seen; i++) begin
         @(negedge clock_i);
         if (cmd_exec_o === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL gap_first_exec got=0 expected=1");
      end
      reset_i = 1'b1;
      @(negedge clock_i);
      checks++;
      if ({ddr_cmd_o, cmd_exec_o, rd_start_o} !== {C_NOP, 2'b00}) begin
         failures++;
         $display("FAIL gap_reset got=%b expected=%b", {ddr_cmd_o, cmd_exec_o, rd_start_o}, {C_NOP, 2'b00});
      end
      reset_i     = 1'b0;
      cmd_start_i = 1'b0;
      ready_cyc   = cyc + 1;
      repeat (5) begin
         @(negedge clock_i);
         checks++;
         if ({ddr_cmd_o, cmd_exec_o, ddr_idle_o} !== {C_NOP, 2'b01}) begin
            failures++;
            $display("FAIL gap_after_reset got=%b expected=%b", {ddr_cmd_o, cmd_exec_o, ddr_idle_o}, {C_NOP, 2'b01});
         end
      end
   endtask

   task automatic test_random();
      int n, ab, gap;
      for (int t = 0; t < 14; t++) begin
         gap = $urandom_range(0, 2);
         repeat (gap) @(negedge clock_i);
         if ($urandom_range(0, 3) == 0) do_refresh(1'($urandom));
         n  = $urandom_range(1, 4);
         ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n) : 0;
         run_xfer(1'($urandom), 2'($urandom), 13'($urandom), n, ab, 9'h0, 0, 1'b1, 1'($urandom));
      end
   endtask

   task automatic test_back_to_back();
      run_xfer(1'b0, 2'd0, 13'h0001, 2, 0, 9'h100, 2, 1'b0, 1'b0);
      run_xfer(1'b1, 2'd3, 13'h1000, 3, 0, 9'h000, 0, 1'b1, 1'b0);
      do_refresh(1'b0);
      run_xfer(1'b1, 2'd2, 13'h0777, 1, 0, 9'h1FF, 0, 1'b0, 1'b0);
   endtask

   initial begin
      @(negedge clock_i);
      test_reset();
      test_single_read();
      test_block_write();
      test_refresh_vs_start();
      test_abort();
      test_enable();
      test_reset_in_gap();
      test_back_to_back();
      test_random();
      repeat (4) @(negedge clock_i);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
